// File: rtl/oob_link_sequencer.sv
// Supervisor for the SATA OOB controller: bring-up retries with backoff, phy_ready debounce,
// and AHCI COMRESET/offline handling. Optional link-loss statistic behind OOB_SEQ_STATS_EN.
module oob_link_sequencer #(
  parameter int unsigned RETRY_MAX     = 8,
  parameter logic [23:0] LINK_TIMEOUT  = 24'd1000000,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned BACKOFF_BASE  = 1024,
  parameter int unsigned RST_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gtx_ready,
  input  logic        phy_ready,
  input  logic        host_comreset,
  input  logic        host_offline,
  output logic        oob_rst,
  output logic        set_offline,
  output logic        comreset_send,
  output logic        link_ok,
  output logic        link_failed,
  output logic [3:0]  retry_cnt,
  output logic [2:0]  seq_state,
  output logic [15:0] link_loss_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_UP        = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_FAILED    = 3'd5,
    ST_OFFLINE   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [15:0] stab_q, stab_d;
  logic [3:0]  retry_q, retry_d;
  logic        failed_q, failed_d;
  logic        oob_rst_q, set_offline_q, comreset_q, link_ok_q;
  logic        enter_reset, go_offline;

  logic [23:0] timer_inc;
  logic [15:0] stab_inc;
  logic [3:0]  retry_sat;
  logic [2:0]  backoff_shift;
  logic [23:0] backoff_len;

  assign timer_inc     = timer_q + 24'd1;
  assign stab_inc      = stab_q + 16'd1;
  assign retry_sat     = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
  assign backoff_shift = (retry_q > 4'd4) ? 3'd4 : retry_q[2:0];
  assign backoff_len   = 24'(BACKOFF_BASE) << backoff_shift;

  // Every transition restarts the shared timer; only dwelling in a timed state advances it.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    stab_d      = '0;
    retry_d     = retry_q;
    failed_d    = failed_q;
    enter_reset = 1'b0;
    go_offline  = 1'b0;
    if (!gtx_ready) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d     = ST_RESET;
      enter_reset = 1'b1;
    end else if (host_comreset) begin
      state_d     = ST_RESET;
      retry_d     = '0;
      failed_d    = 1'b0;
      enter_reset = 1'b1;
    end else if (host_offline) begin
      state_d    = ST_OFFLINE;
      go_offline = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_inc == 24'(RST_CYCLES)) state_d = ST_WAIT_LINK;
          else                              timer_d = timer_inc;
        end
        ST_WAIT_LINK: begin
          if (phy_ready) stab_d = stab_inc;
          // A stable link on the timeout cycle still counts as success.
          if (phy_ready && (stab_inc == 16'(STABLE_CYCLES))) begin
            state_d = ST_UP;
            retry_d = '0;
            stab_d  = '0;
          end else if (timer_inc == LINK_TIMEOUT) begin
            retry_d = retry_sat;
            stab_d  = '0;
            if (retry_sat >= 4'(RETRY_MAX)) begin
              state_d  = ST_FAILED;
              failed_d = 1'b1;
            end else begin
              state_d = ST_BACKOFF;
            end
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_UP: begin
          if (!phy_ready) begin
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (timer_inc == backoff_len) begin
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_FAILED, ST_OFFLINE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      stab_q        <= '0;
      retry_q       <= '0;
      failed_q      <= 1'b0;
      oob_rst_q     <= 1'b1;
      set_offline_q <= 1'b0;
      comreset_q    <= 1'b0;
      link_ok_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stab_q        <= stab_d;
      retry_q       <= retry_d;
      failed_q      <= failed_d;
      oob_rst_q     <= !((state_d == ST_WAIT_LINK) || (state_d == ST_UP) || (state_d == ST_OFFLINE));
      set_offline_q <= go_offline;
      comreset_q    <= enter_reset;
      link_ok_q     <= (state_d == ST_UP);
    end
  end

  assign oob_rst       = oob_rst_q;
  assign set_offline   = set_offline_q;
  assign comreset_send = comreset_q;
  assign link_ok       = link_ok_q;
  assign link_failed   = failed_q;
  assign retry_cnt     = retry_q;
  assign seq_state     = state_q;

`ifdef OOB_SEQ_STATS_EN
  logic [15:0] loss_cnt_q;
  logic        loss_evt;

  assign loss_evt = (state_q == ST_UP) && (state_d == ST_RESET) && !host_comreset;

  always_ff @(posedge clk) begin
    if (rst)                                     loss_cnt_q <= '0;
    else if (loss_evt && (loss_cnt_q != 16'hFFFF)) loss_cnt_q <= loss_cnt_q + 16'd1;
  end

  assign link_loss_cnt = loss_cnt_q;
`else
  assign link_loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_oob_link_sequencer.sv
// Directed bench for oob_link_sequencer: expectations queued at stimulus time, checked on DUT response.
module tb_oob_link_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_WAIT = 3'd2, S_UP = 3'd3,
                         S_BACKOFF = 3'd4, S_FAILED = 3'd5, S_OFFLINE = 3'd6;

  logic        clk = 1'b0;
  logic        rst, gtx_ready, phy_ready, host_comreset, host_offline;
  logic        oob_rst, set_offline, comreset_send, link_ok, link_failed;
  logic [3:0]  retry_cnt;
  logic [2:0]  seq_state;
  logic [15:0] link_loss_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oob_link_sequencer #(
    .RETRY_MAX    (3),
    .LINK_TIMEOUT (24'd200),
    .STABLE_CYCLES(16),
    .BACKOFF_BASE (32),
    .RST_CYCLES   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gtx_ready    (gtx_ready),
    .phy_ready    (phy_ready),
    .host_comreset(host_comreset),
    .host_offline (host_offline),
    .oob_rst      (oob_rst),
    .set_offline  (set_offline),
    .comreset_send(comreset_send),
    .link_ok      (link_ok),
    .link_failed  (link_failed),
    .retry_cnt    (retry_cnt),
    .seq_state    (seq_state),
    .link_loss_cnt(link_loss_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) begin
      passes++;
      $display("check %-22s observed %0d expected %0d ok", e.tag, obs, e.val);
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (seq_state !== s && n < budget) begin
      tick();
      n++;
    end
    if (seq_state !== s) n = -1;
  endtask

  task automatic dwell(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (seq_state === s && n < budget) begin
      n++;
      tick();
    end
  endtask

  int n, g, pulses, k;
  logic saw_up;

  initial begin
    rst = 1'b1; gtx_ready = 1'b0; phy_ready = 1'b0; host_comreset = 1'b0; host_offline = 1'b0;
    repeat (3) tick();

    // Reset values
    expect_val("rst_oob_rst", 1); expect_val("rst_link_ok", 0); expect_val("rst_link_failed", 0);
    expect_val("rst_retry", 0); expect_val("rst_state", S_IDLE); expect_val("rst_loss_cnt", 0);
    expect_val("rst_comreset", 0); expect_val("rst_set_offline", 0);
    observe(oob_rst); observe(link_ok); observe(link_failed);
    observe(retry_cnt); observe(seq_state); observe(link_loss_cnt);
    observe(comreset_send); observe(set_offline);

    rst = 1'b0;
    expect_val("idle_hold", S_IDLE);
    repeat (9) tick();
    observe(seq_state);

    // Nominal bring-up: phy_ready arrives 50 cycles after gtx_ready
    g = cyc;
    gtx_ready = 1'b1;
    expect_val("nom_reset_entry", S_RESET); expect_val("nom_comreset", 1);
    tick();
    observe(seq_state); observe(comreset_send);
    pulses = 1; n = 0;
    expect_val("nom_oob_rst_len", 8);
    while (oob_rst === 1'b1 && n < 20) begin
      tick(); n++;
      if (comreset_send === 1'b1) pulses++;
    end
    observe(n);
    while (cyc < g + 50) begin
      tick();
      if (comreset_send === 1'b1) pulses++;
    end
    phy_ready = 1'b1;
    expect_val("nom_link_up_cycle", 1);
    n = 0;
    while (link_ok !== 1'b1 && n < 40) begin
      tick(); n++;
      if (comreset_send === 1'b1) pulses++;
    end
    observe(((cyc - g) == 66) || ((cyc - g) == 67));
    expect_val("nom_comreset_pulses", 1); expect_val("nom_retry", 0);
    expect_val("nom_state", S_UP); expect_val("nom_oob_rst", 0);
    observe(pulses); observe(retry_cnt); observe(seq_state); observe(oob_rst);

    // Link loss: one-cycle drop in UP
    phy_ready = 1'b0;
    expect_val("loss_link_ok", 0); expect_val("loss_state", S_RESET); expect_val("loss_comreset", 1);
`ifdef OOB_SEQ_STATS_EN
    expect_val("loss_cnt", 1);
`else
    expect_val("loss_cnt", 0);
`endif
    tick();
    phy_ready = 1'b1;
    observe(link_ok); observe(seq_state); observe(comreset_send); observe(link_loss_cnt);
    expect_val("loss_relink_cycles", 24);
    wait_state(S_UP, 60, n);
    observe(n);

    // Offline, then COMRESET brings the link back
    host_offline = 1'b1;
    expect_val("off_state", S_OFFLINE); expect_val("off_pulse", 1);
    expect_val("off_link_ok", 0); expect_val("off_oob_rst", 0);
    tick();
    host_offline = 1'b0;
    observe(seq_state); observe(set_offline); observe(link_ok); observe(oob_rst);
    expect_val("off_hold_state", S_OFFLINE); expect_val("off_pulse_once", 0);
    repeat (5) tick();
    observe(seq_state); observe(set_offline);
    host_comreset = 1'b1;
    expect_val("off_cr_state", S_RESET); expect_val("off_cr_comreset", 1);
    expect_val("off_cr_retry", 0); expect_val("off_cr_failed", 0);
    tick();
    host_comreset = 1'b0;
    observe(seq_state); observe(comreset_send); observe(retry_cnt); observe(link_failed);
    expect_val("off_relink_cycles", 24); expect_val("off_relink_ok", 1);
    wait_state(S_UP, 60, n);
    observe(n); observe(link_ok);

    // No response: three timeouts, backoffs 64 then 128, then FAILED
    phy_ready = 1'b0;
    tick();
    wait_state(S_WAIT, 20, n);
    expect_val("nr_wait1_len", 200); expect_val("nr_retry1", 1); expect_val("nr_backoff1", 64);
    dwell(S_WAIT, 300, n);
    observe(n); observe(retry_cnt);
    dwell(S_BACKOFF, 300, n);
    observe(n);
    wait_state(S_WAIT, 20, n);
    dwell(S_WAIT, 300, n);
    expect_val("nr_retry2", 2); expect_val("nr_backoff2", 128);
    observe(retry_cnt);
    dwell(S_BACKOFF, 300, n);
    observe(n);
    expect_val("nr_failed_state", S_FAILED); expect_val("nr_failed_flag", 1);
    expect_val("nr_failed_retry", 3); expect_val("nr_failed_oob_rst", 1);
    wait_state(S_FAILED, 300, n);
    observe(seq_state); observe(link_failed); observe(retry_cnt); observe(oob_rst);
    expect_val("nr_failed_held", S_FAILED);
    repeat (20) tick();
    observe(seq_state);

    // Glitchy link: 10 high / 1 low never debounces, timeout -> BACKOFF
    host_comreset = 1'b1;
    expect_val("gl_cr_retry", 0); expect_val("gl_cr_failed", 0);
    tick();
    host_comreset = 1'b0;
    observe(retry_cnt); observe(link_failed);
    k = 0; saw_up = 1'b0;
    expect_val("gl_no_link_ok", 0); expect_val("gl_state", S_BACKOFF); expect_val("gl_retry", 1);
    while (seq_state !== S_BACKOFF && k < 400) begin
      phy_ready = ((k % 11) != 10);
      tick(); k++;
      if (link_ok === 1'b1) saw_up = 1'b1;
    end
    observe(saw_up); observe(seq_state); observe(retry_cnt);

    // Simultaneous events
    phy_ready = 1'b0;
    host_comreset = 1'b1; host_offline = 1'b1;
    expect_val("sim_cr_wins", S_RESET); expect_val("sim_comreset", 1); expect_val("sim_no_offline", 0);
    tick();
    host_comreset = 1'b0; host_offline = 1'b0;
    observe(seq_state); observe(comreset_send); observe(set_offline);
    repeat (2) tick();
    gtx_ready = 1'b0; host_comreset = 1'b1;
    expect_val("sim_idle_wins", S_IDLE); expect_val("sim_idle_oob_rst", 1);
    expect_val("sim_idle_comreset", 0); expect_val("sim_idle_link_ok", 0);
    tick();
    host_comreset = 1'b0;
    observe(seq_state); observe(oob_rst); observe(comreset_send); observe(link_ok);
`ifdef OOB_SEQ_STATS_EN
    expect_val("final_loss_cnt", 2);
`else
    expect_val("final_loss_cnt", 0);
`endif
    observe(link_loss_cnt);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/oob_link_sequencer.md
Name: oob_link_sequencer

Overview:
- Supervisor that sequences the SATA OOB controller: restarts link bring-up, retries with exponential backoff, and debounces phy_ready into a stable link indication.
- Converts AHCI requests (COMRESET, go-offline) into the controller's rst / set_offline / comreset_send controls.
- Sits between the AHCI register/FSM layer and the OOB controller instance, in the sata clk (usrclk2) domain.

Parameters:
- RETRY_MAX, 8: failed bring-up attempts before declaring FAILED (1..15).
- LINK_TIMEOUT, 24'd1000000: cycles allowed from oob_rst release to stable link.
- STABLE_CYCLES, 256: consecutive phy_ready cycles required to declare link up (1..65535).
- BACKOFF_BASE, 1024: base backoff in cycles; actual backoff = BACKOFF_BASE << min(retry_cnt,4).
- RST_CYCLES, 8: oob_rst pulse length (1..255).

Ports:
- clk  in  1  sata clock (usrclk2)
- rst  in  1  synchronous, active-high reset
- gtx_ready  in  1  transceiver resets complete
- phy_ready  in  1  link status from OOB controller
- host_comreset  in  1  one-cycle pulse: AHCI requests COMRESET
- host_offline  in  1  one-cycle pulse: AHCI requests offline
- oob_rst  out  1  reset to OOB controller
- set_offline  out  1  one-cycle pulse to OOB controller
- comreset_send  out  1  one-cycle pulse to OOB controller
- link_ok  out  1  debounced link-up
- link_failed  out  1  retries exhausted (sticky until host_comreset or rst)
- retry_cnt  out  4  attempts failed since last success or COMRESET
- seq_state  out  3  current state encoding (debug)
- link_loss_cnt  out  16  link-loss statistic (see Optional Feature)

Behaviour:
- Reset values: oob_rst=1, set_offline=0, comreset_send=0, link_ok=0, link_failed=0, retry_cnt=0, seq_state=IDLE(0), link_loss_cnt=0; all timers 0.
- States: IDLE=0, RESET=1, WAIT_LINK=2, UP=3, BACKOFF=4, FAILED=5, OFFLINE=6.
- IDLE: oob_rst=1. Moves to RESET on the cycle gtx_ready=1.
- RESET:
  - oob_rst=1 for exactly RST_CYCLES cycles.
  - On the entry cycle, comreset_send pulses for 1 cycle.
  - Then go to WAIT_LINK with the timer cleared.
- WAIT_LINK:
  - oob_rst=0; timer increments every cycle.
  - Stability counter increments while phy_ready=1 and clears to 0 when phy_ready=0.
  - When the stability counter reaches STABLE_CYCLES: go to UP and clear retry_cnt. link_ok rises on the first UP cycle.
  - When the timer reaches LINK_TIMEOUT first: retry_cnt+1, then FAILED if the new retry_cnt==RETRY_MAX, else BACKOFF.
  - If both conditions occur on the same cycle, UP wins.
- UP:
  - link_ok=1.
  - phy_ready=0 for one cycle means link loss: link_ok drops next cycle, link_loss_cnt+1, go to RESET (retry_cnt unchanged).
- BACKOFF:
  - oob_rst=1; count BACKOFF_BASE << min(retry_cnt,4) cycles, then go to RESET.
  - Shift is computed in a 24-bit timer; no overflow for legal parameters.
- FAILED: oob_rst=1, link_failed=1. Held until host_comreset or rst.
- OFFLINE:
  - Entered from any state except IDLE on host_offline.
  - set_offline pulses on the entry cycle; link_ok=0; oob_rst=0 (controller holds txelecidle).
  - Exits only on host_comreset.
- host_comreset, from any state except IDLE:
  - Next state RESET; retry_cnt=0, link_failed=0.
  - comreset_send is issued by RESET entry.
- Priority on the same cycle: rst > gtx_ready=0 > host_comreset > host_offline > internal transitions.
- gtx_ready=0 in any state: next state IDLE, link_ok=0, retry_cnt preserved, link_failed preserved.
- retry_cnt saturates at 15. link_loss_cnt saturates at 16'hFFFF.
- All outputs are registered. State changes take effect on the next clock edge.

Optional Feature:
- Macro: OOB_SEQ_STATS_EN.
- Defined: link_loss_cnt counts UP→RESET link losses; it saturates and clears only on rst.
- Undefined: link_loss_cnt is tied to 16'h0000 and its counter logic is not built; all other behaviour is identical.

Test Plan (bench params: RETRY_MAX=3, LINK_TIMEOUT=200, STABLE_CYCLES=16, BACKOFF_BASE=32, RST_CYCLES=8):
- Nominal bring-up. Stimulus: gtx_ready=1 at cycle 10; phy_ready=1 from cycle 60 onward. Response: comreset_send pulse once; oob_rst low after 8 cycles; link_ok=1 at cycle 76 or 77; retry_cnt=0.
- No response. Stimulus: phy_ready stays 0. Response: three WAIT_LINK timeouts, with backoffs of 64 then 128 cycles (BACKOFF_BASE<<1, <<2); link_failed=1 with retry_cnt=3; oob_rst=1 held.
- Glitchy link. Stimulus: phy_ready toggles with 10-cycle high / 1-cycle low pulses. Response: link_ok never asserts; timeout leads to BACKOFF.
- Link loss. Stimulus: in UP, drop phy_ready for 1 cycle. Response: link_ok=0 next cycle; state RESET; comreset_send pulse; with OOB_SEQ_STATS_EN, link_loss_cnt=1.
- Offline then COMRESET. Stimulus: host_offline in UP, later host_comreset. Response: set_offline pulse; link_ok=0; state OFFLINE held; COMRESET clears link_failed and retry_cnt, restarts RESET, and the link comes back up.
- Simultaneous events. Stimulus: host_comreset and host_offline on the same cycle, then gtx_ready=0 together with host_comreset. Response: RESET wins in the first case; IDLE wins in the second case.
